// File: rtl/laser_cover_scorer.sv
// Coverage scorer for the laser-treatment solver: captures the 40-point load stream,
// then on each solver DONE counts points inside circle 1, circle 2 and their union.
module laser_cover_scorer #(
  parameter int NPTS = 40,
  parameter int R2   = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  input  logic       DONE,
  output logic [5:0] SCORE,
  output logic [5:0] SCORE1,
  output logic [5:0] SCORE2,
  output logic       VALID,
  output logic       BUSY
);

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_SCAN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);
  localparam logic [8:0] R2_W     = 9'(R2);

  state_t     state;
  logic [5:0] load_idx;
  logic [5:0] scan_idx;
  logic [5:0] acc1, acc2, acc_u;
  logic [7:0] mem [NPTS];
  logic [3:0] c1x_q, c1y_q, c2x_q, c2y_q;

  logic [7:0] pt;
  logic       hit1, hit2, hit_u;

  // Squared distance kept at full 9-bit width so the corner case (450) cannot wrap.
  function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic [3:0] dx, dy;
    logic [8:0] sx, sy;
    dx = (px >= cx) ? (px - cx) : (cx - px);
    dy = (py >= cy) ? (py - cy) : (cy - py);
    sx = {5'b0, dx} * {5'b0, dx};
    sy = {5'b0, dy} * {5'b0, dy};
    return sx + sy;
  endfunction

  assign pt    = mem[scan_idx];
  assign hit1  = dist_sq(pt[7:4], pt[3:0], c1x_q, c1y_q) <= R2_W;
  assign hit2  = dist_sq(pt[7:4], pt[3:0], c2x_q, c2y_q) <= R2_W;
  assign hit_u = hit1 | hit2;
  assign BUSY  = (state != S_WAIT);

  // Point storage and latched centres carry no reset; control below gates their use.
  always_ff @(posedge CLK) begin
    if (state == S_LOAD) mem[load_idx] <= {X, Y};
    if (state == S_WAIT && DONE) begin
      c1x_q <= C1X;
      c1y_q <= C1Y;
      c2x_q <= C2X;
      c2y_q <= C2Y;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_LOAD;
      load_idx <= '0;
      scan_idx <= '0;
      acc1     <= '0;
      acc2     <= '0;
      acc_u    <= '0;
      SCORE    <= '0;
      SCORE1   <= '0;
      SCORE2   <= '0;
      VALID    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      case (state)
        S_LOAD: begin
          load_idx <= load_idx + 6'd1;
          if (load_idx == LAST_IDX) state <= S_WAIT;
        end
        S_WAIT: begin
          if (DONE) begin
            acc1     <= '0;
            acc2     <= '0;
            acc_u    <= '0;
            scan_idx <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          acc1     <= acc1 + {5'b0, hit1};
          acc2     <= acc2 + {5'b0, hit2};
          acc_u    <= acc_u + {5'b0, hit_u};
          scan_idx <= scan_idx + 6'd1;
          if (scan_idx == LAST_IDX) begin
            SCORE  <= acc_u + {5'b0, hit_u};
            SCORE1 <= acc1 + {5'b0, hit1};
            SCORE2 <= acc2 + {5'b0, hit2};
            VALID  <= 1'b1;
            state  <= S_WAIT;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_scorer.sv
// Directed bench for laser_cover_scorer: hand-computed scores for several point sets.
module tb_laser_cover_scorer;

  localparam int NPTS = 40;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] X = '0, Y = '0;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       DONE = 1'b0;
  logic [5:0] SCORE, SCORE1, SCORE2;
  logic       VALID, BUSY;

  int total = 0;
  int bad = 0;

  logic [3:0] px [NPTS];
  logic [3:0] py [NPTS];

  laser_cover_scorer #(.NPTS(NPTS), .R2(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .X(X), .Y(Y),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE),
    .SCORE(SCORE), .SCORE1(SCORE1), .SCORE2(SCORE2), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [3:0] x, input logic [3:0] y);
    for (int i = 0; i < NPTS; i++) begin
      px[i] = x;
      py[i] = y;
    end
  endtask

  // Asserts reset mid-cycle, checks immediate clearing, releases at a falling edge.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    RST_N = 1'b0;
    DONE  = 1'b0;
    #1;
    check_val({tag, "_rst_score"}, 32'(SCORE), 0);
    check_val({tag, "_rst_score1"}, 32'(SCORE1), 0);
    check_val({tag, "_rst_score2"}, 32'(SCORE2), 0);
    check_val({tag, "_rst_valid"}, 32'(VALID), 0);
    check_val({tag, "_rst_busy"}, 32'(BUSY), 1);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // Called right at the release falling edge; optionally raises DONE during one load cycle.
  task automatic load_pts(input string tag, input int done_at);
    for (int i = 0; i < NPTS; i++) begin
      X = px[i];
      Y = py[i];
      if (i == done_at) begin
        DONE = 1'b1;
        C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
      end else begin
        DONE = 1'b0;
      end
      @(negedge CLK);
    end
    DONE = 1'b0;
    check_val({tag, "_load_busy"}, 32'(BUSY), 0);
    check_val({tag, "_load_valid"}, 32'(VALID), 0);
  endtask

  task automatic run_scan(input string tag,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d,
                          input int es, input int e1, input int e2, input bit inject);
    int n;
    bit got;
    @(negedge CLK);
    C1X = a; C1Y = b; C2X = c; C2Y = d;
    DONE = 1'b1;
    @(posedge CLK);
    #1;
    DONE = 1'b0;
    check_val({tag, "_busy_rise"}, 32'(BUSY), 1);
    n = 0;
    got = 1'b0;
    while (n < 60 && !got) begin
      @(posedge CLK);
      #1;
      n++;
      if (inject && n == 5) begin
        C1X = 4'd12; C1Y = 4'd12; C2X = 4'd12; C2Y = 4'd12;
        DONE = 1'b1;
      end
      if (n == 6) DONE = 1'b0;
      if (VALID) got = 1'b1;
    end
    check_val({tag, "_latency"}, 32'(n), 40);
    check_val({tag, "_score"}, 32'(SCORE), 32'(es));
    check_val({tag, "_score1"}, 32'(SCORE1), 32'(e1));
    check_val({tag, "_score2"}, 32'(SCORE2), 32'(e2));
    check_val({tag, "_busy_fall"}, 32'(BUSY), 0);
    @(posedge CLK);
    #1;
    check_val({tag, "_valid_clr"}, 32'(VALID), 0);
    check_val({tag, "_hold"}, 32'(SCORE), 32'(es));
  endtask

  initial begin
    // All points on circle 1's centre; circle 2 far away.
    do_reset("init");
    fill(4'd8, 4'd8);
    load_pts("a", -1);
    run_scan("a", 4'd8, 4'd8, 4'd0, 4'd0, 40, 40, 0, 1'b0);

    // Radius boundary, with a DONE during load that must be ignored.
    do_reset("b");
    fill(4'd15, 4'd0);
    px[0] = 4'd12; py[0] = 4'd8;
    px[1] = 4'd11; py[1] = 4'd10;
    px[2] = 4'd8;  py[2] = 4'd4;
    px[3] = 4'd11; py[3] = 4'd11;
    px[4] = 4'd13; py[4] = 4'd8;
    load_pts("b", 10);
    run_scan("b", 4'd8, 4'd8, 4'd0, 4'd15, 3, 3, 0, 1'b0);

    // Corner arithmetic: (0,0) vs (15,15) sums to 450 and must miss.
    do_reset("c");
    fill(4'd0, 4'd0);
    px[17] = 4'd15; py[17] = 4'd15;
    load_pts("c", -1);
    run_scan("c", 4'd15, 4'd15, 4'd15, 4'd15, 1, 1, 1, 1'b0);

    // Overlap, then re-score without reload, then ignored mid-scan strobe.
    do_reset("d");
    for (int i = 0; i < NPTS; i++) begin
      px[i] = (i < 20) ? 4'd4 : 4'd12;
      py[i] = (i < 20) ? 4'd4 : 4'd12;
    end
    load_pts("d", -1);
    run_scan("d1", 4'd4, 4'd4, 4'd4, 4'd4, 20, 20, 20, 1'b0);
    run_scan("d2", 4'd4, 4'd4, 4'd12, 4'd12, 40, 20, 20, 1'b0);
    run_scan("d3", 4'd4, 4'd4, 4'd4, 4'd4, 20, 20, 20, 1'b1);

    // Abort a scan with reset, reload and confirm no residue.
    @(negedge CLK);
    C1X = 4'd4; C1Y = 4'd4; C2X = 4'd12; C2Y = 4'd12;
    DONE = 1'b1;
    @(posedge CLK);
    #1;
    DONE = 1'b0;
    repeat (19) @(posedge CLK);
    #1;
    check_val("e_no_early_valid", 32'(VALID), 0);
    check_val("e_prev_score", 32'(SCORE), 20);
    do_reset("e");
    fill(4'd8, 4'd8);
    px[0] = 4'd0; py[0] = 4'd0;
    load_pts("e", -1);
    run_scan("e", 4'd8, 4'd8, 4'd8, 4'd8, 39, 39, 39, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
